// File: rtl/ex_stage_pkg.sv
// Shared op codes, result classes, bus widths and divider states
// for the execute stage.
package ex_stage_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int ALU_OP_W   = 8;
    localparam int ALU_SEL_W  = 3;
    localparam int REG_ADDR_W = 5;

    typedef logic [ALU_OP_W-1:0]  alu_op_t;
    typedef logic [ALU_SEL_W-1:0] alu_sel_t;

    localparam alu_op_t EXE_NOP_OP  = 8'b0000_0000;
    localparam alu_op_t EXE_AND_OP  = 8'b0010_0100;
    localparam alu_op_t EXE_OR_OP   = 8'b0010_0101;
    localparam alu_op_t EXE_XOR_OP  = 8'b0010_0110;
    localparam alu_op_t EXE_NOR_OP  = 8'b0010_0111;
    localparam alu_op_t EXE_SLL_OP  = 8'b0111_1100;
    localparam alu_op_t EXE_SRL_OP  = 8'b0000_0010;
    localparam alu_op_t EXE_SRA_OP  = 8'b0000_0011;
    localparam alu_op_t EXE_ADD_OP  = 8'b0010_0000;
    localparam alu_op_t EXE_SUB_OP  = 8'b0010_0010;
    localparam alu_op_t EXE_SLT_OP  = 8'b0010_1010;
    localparam alu_op_t EXE_SLTU_OP = 8'b0010_1011;
    localparam alu_op_t EXE_DIV_OP  = 8'b0001_1010;
    localparam alu_op_t EXE_DIVU_OP = 8'b0001_1011;

    localparam alu_sel_t EXE_RES_NOP   = 3'b000;
    localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
    localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
    localparam alu_sel_t EXE_RES_ARITH = 3'b100;

    localparam logic [1:0] DIV_IDLE   = 2'b00;
    localparam logic [1:0] DIV_BYZERO = 2'b01;
    localparam logic [1:0] DIV_BUSY   = 2'b10;
    localparam logic [1:0] DIV_END    = 2'b11;

    function automatic logic is_div_op(alu_op_t op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX operand bundle in, EX/MEM result bundle and stall out.
// master = ID/EX side, slave = execute stage.
interface ex_stage_if
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
);
    logic [DATA_W-1:0]     ex_data_a_i;
    logic [DATA_W-1:0]     ex_data_b_i;
    logic                  ex_we_i;
    logic [REG_ADDR_W-1:0] ex_w_reg_addr_i;
    alu_sel_t              ex_sel_i;
    alu_op_t               ex_op_i;

    logic                  mem_we_o;
    logic [REG_ADDR_W-1:0] mem_w_reg_addr_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_whilo_o;
    logic [DATA_W-1:0]     mem_hi_o;
    logic [DATA_W-1:0]     mem_lo_o;
    logic                  stallreq_o;

    modport master (
        output ex_data_a_i, ex_data_b_i, ex_we_i,
        output ex_w_reg_addr_i, ex_sel_i, ex_op_i,
        input  mem_we_o, mem_w_reg_addr_o, mem_wdata_o,
        input  mem_whilo_o, mem_hi_o, mem_lo_o, stallreq_o
    );

    modport slave (
        input  ex_data_a_i, ex_data_b_i, ex_we_i,
        input  ex_w_reg_addr_i, ex_sel_i, ex_op_i,
        output mem_we_o, mem_w_reg_addr_o, mem_wdata_o,
        output mem_whilo_o, mem_hi_o, mem_lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_div.sv
// Iterative restoring divider (one quotient bit per cycle).
// Signed DIV support is compiled in with EX_DIV_SIGNED_EN.
module ex_div
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int DIV_ITER = DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_signed,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int SR_W = 2 * DATA_W + 1;

    logic [1:0]        state;
    logic [5:0]        cnt;
    logic [SR_W-1:0]   sr;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] mag_a;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] q_res;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W:0]   diff;
    logic              b_zero;

    assign b_zero = (op_b == '0);

`ifdef EX_DIV_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic a_neg;
    logic b_neg;

    assign a_neg = is_signed & op_a[DATA_W-1];
    assign b_neg = is_signed & op_b[DATA_W-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

    // Divide-by-zero results are raw, so no fixup there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            neg_q <= !b_zero & (a_neg ^ b_neg);
            neg_r <= !b_zero & a_neg;
        end
    end

    assign q_res = neg_q ? -sr[DATA_W-1:0] : sr[DATA_W-1:0];
    assign r_res = neg_r ? -sr[SR_W-1:DATA_W+1]
                         : sr[SR_W-1:DATA_W+1];
`else
    logic unused_signed;

    assign unused_signed = is_signed;
    assign mag_a = op_a;
    assign mag_b = op_b;
    assign q_res = sr[DATA_W-1:0];
    assign r_res = sr[SR_W-1:DATA_W+1];
`endif

    assign diff = {1'b0, sr[2*DATA_W-1:DATA_W]}
                - {1'b0, divisor};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            sr      <= '0;
            divisor <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && b_zero) begin
                        state <= DIV_BYZERO;
                        sr    <= {op_a, 1'b0, {DATA_W{1'b1}}};
                    end else if (start) begin
                        state   <= DIV_BUSY;
                        cnt     <= '0;
                        divisor <= mag_b;
                        sr      <= {{DATA_W{1'b0}}, mag_a, 1'b0};
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state <= DIV_IDLE;
                    end else begin
                        if (diff[DATA_W])
                            sr <= {sr[2*DATA_W-1:0], 1'b0};
                        else
                            sr <= {diff[DATA_W-1:0],
                                   sr[DATA_W-1:0], 1'b1};
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'(DIV_ITER - 1))
                            state <= DIV_END;
                    end
                end
                DIV_BYZERO: begin
                    state <= cancel ? DIV_IDLE : DIV_END;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == DIV_BUSY) || (state == DIV_BYZERO);
    assign done      = (state == DIV_END);
    assign quotient  = done ? q_res : '0;
    assign remainder = done ? r_res : '0;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU result mux, divider hookup and stall request.
// Define EX_DIV_SIGNED_EN to make DIV a signed divide.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int DIV_ITER = DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    localparam int SH_W = $clog2(DATA_W);

    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SH_W-1:0]   shamt;
    alu_op_t           op;
    alu_sel_t          sel;
    logic [DATA_W-1:0] wdata;
    logic              div_op;
    logic              div_signed;
    logic              div_busy;
    logic              div_done;
    logic [DATA_W-1:0] div_q;
    logic [DATA_W-1:0] div_r;

    assign a      = bus.ex_data_a_i;
    assign b      = bus.ex_data_b_i;
    assign op     = bus.ex_op_i;
    assign sel    = bus.ex_sel_i;
    assign shamt  = a[SH_W-1:0];
    assign div_op = is_div_op(op);

`ifdef EX_DIV_SIGNED_EN
    assign div_signed = (op == EXE_DIV_OP);
`else
    assign div_signed = 1'b0;
`endif

    always_comb begin
        wdata = '0;
        unique case (1'b1)
            (sel == EXE_RES_LOGIC): begin
                case (op)
                    EXE_AND_OP: wdata = a & b;
                    EXE_OR_OP:  wdata = a | b;
                    EXE_XOR_OP: wdata = a ^ b;
                    EXE_NOR_OP: wdata = ~(a | b);
                    default:    wdata = '0;
                endcase
            end
            (sel == EXE_RES_SHIFT): begin
                case (op)
                    EXE_SLL_OP: wdata = b << shamt;
                    EXE_SRL_OP: wdata = b >> shamt;
                    EXE_SRA_OP: wdata = $signed(b) >>> shamt;
                    default:    wdata = '0;
                endcase
            end
            (sel == EXE_RES_ARITH): begin
                case (op)
                    EXE_ADD_OP:  wdata = a + b;
                    EXE_SUB_OP:  wdata = a - b;
                    EXE_SLT_OP:
                        wdata = {{(DATA_W-1){1'b0}},
                                 $signed(a) < $signed(b)};
                    EXE_SLTU_OP:
                        wdata = {{(DATA_W-1){1'b0}}, a < b};
                    default:     wdata = '0;
                endcase
            end
            default: wdata = '0;
        endcase
    end

    ex_div #(
        .DATA_W   (DATA_W),
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_op),
        .is_signed (div_signed),
        .op_a      (a),
        .op_b      (b),
        .cancel    (!div_op),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .remainder (div_r)
    );

    // Divides only write HI/LO, never the register file.
    assign bus.mem_we_o         = bus.ex_we_i & !div_op;
    assign bus.mem_w_reg_addr_o = bus.ex_w_reg_addr_i;
    assign bus.mem_wdata_o      = wdata;
    assign bus.mem_whilo_o      = div_done;
    assign bus.mem_hi_o         = div_r;
    assign bus.mem_lo_o         = div_q;

    assign bus.stallreq_o = rst & ((div_op & !div_busy & !div_done)
                                   | div_busy);

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU classes, divider timing,
// divide-by-zero, abort and mid-divide reset.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    ex_stage_if #(.DATA_W(32)) bus();

    ex_stage #(
        .DATA_W   (32),
        .DIV_ITER (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input alu_op_t op, input alu_sel_t sel,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic we, input logic [4:0] wa);
        bus.ex_op_i         = op;
        bus.ex_sel_i        = sel;
        bus.ex_data_a_i     = a;
        bus.ex_data_b_i     = b;
        bus.ex_we_i         = we;
        bus.ex_w_reg_addr_i = wa;
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b1, 5'd3);
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if (bus.stallreq_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_stall: got %b expected 0",
                     bus.stallreq_o);
        end
        compared++;
        if ({bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o} !== 65'd0)
        begin
            mismatched++;
            $display("FAIL reset_hilo: got %b %h %h expected 0 0 0",
                     bus.mem_whilo_o, bus.mem_hi_o, bus.mem_lo_o);
        end
        rst = 1'b1;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        next_cycle();
        compared++;
        if (bus.stallreq_o !== 1'b0 || bus.mem_whilo_o !== 1'b0) begin
            mismatched++;
            $display("FAIL post_reset_idle: got stall %b whilo %b expected 0 0",
                     bus.stallreq_o, bus.mem_whilo_o);
        end
    endtask

    task automatic test_logic;
        alu_op_t     ops [4];
        logic [31:0] exp [4];
        ops = '{EXE_AND_OP, EXE_OR_OP, EXE_XOR_OP, EXE_NOR_OP};
        exp = '{32'h00F0_000F, 32'hFFF0_0FFF,
                32'hFF00_0FF0, 32'h000F_F000};
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], EXE_RES_LOGIC, 32'hF0F0_00FF,
                  32'h0FF0_0F0F, 1'b1, 5'd1);
            #1;
            compared++;
            if (bus.mem_wdata_o !== exp[i]) begin
                mismatched++;
                $display("FAIL logic[%0d]: got %h expected %h",
                         i, bus.mem_wdata_o, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_shift;
        alu_op_t     ops [5];
        logic [31:0] va  [5];
        logic [31:0] vb  [5];
        logic [31:0] exp [5];
        ops = '{EXE_SLL_OP, EXE_SRL_OP, EXE_SRA_OP,
                EXE_SRA_OP, EXE_SLL_OP};
        va  = '{32'd4, 32'd4, 32'd4, 32'd31, 32'h0000_0021};
        vb  = '{32'h0000_00F1, 32'hF000_0000, 32'hF000_0000,
                32'h8000_0000, 32'h0000_0001};
        exp = '{32'h0000_0F10, 32'h0F00_0000, 32'hFF00_0000,
                32'hFFFF_FFFF, 32'h0000_0002};
        for (int i = 0; i < 5; i++) begin
            drive(ops[i], EXE_RES_SHIFT, va[i], vb[i], 1'b1, 5'd2);
            #1;
            compared++;
            if (bus.mem_wdata_o !== exp[i]) begin
                mismatched++;
                $display("FAIL shift[%0d]: got %h expected %h",
                         i, bus.mem_wdata_o, exp[i]);
            end
            next_cycle();
        end
    endtask

    task automatic test_arith;
        alu_op_t     ops [6];
        alu_sel_t    sel [6];
        logic [31:0] va  [6];
        logic [31:0] vb  [6];
        logic [31:0] exp [6];
        logic        we;
        ops = '{EXE_ADD_OP, EXE_SUB_OP, EXE_SLT_OP,
                EXE_SLTU_OP, EXE_SLT_OP, EXE_ADD_OP};
        sel = '{EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_ARITH,
                EXE_RES_ARITH, EXE_RES_ARITH, EXE_RES_NOP};
        va  = '{32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'd1, 32'd5};
        vb  = '{32'd1, 32'd1, 32'd1, 32'd1,
                32'hFFFF_FFFF, 32'd6};
        exp = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd1,
                32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 6; i++) begin
            we = i[0];
            drive(ops[i], sel[i], va[i], vb[i], we, 5'(i + 3));
            #1;
            compared++;
            if (bus.mem_wdata_o !== exp[i]) begin
                mismatched++;
                $display("FAIL arith[%0d]: got %h expected %h",
                         i, bus.mem_wdata_o, exp[i]);
            end
            compared++;
            if (bus.mem_we_o !== we ||
                bus.mem_w_reg_addr_o !== 5'(i + 3) ||
                bus.stallreq_o !== 1'b0) begin
                mismatched++;
                $display("FAIL arith_ctl[%0d]: got we %b wa %0d stall %b expected %b %0d 0",
                         i, bus.mem_we_o, bus.mem_w_reg_addr_o,
                         bus.stallreq_o, we, i + 3);
            end
            next_cycle();
        end
    endtask

    task automatic test_div_back_to_back;
        localparam int N = 8;
        alu_op_t     ops [N];
        logic [31:0] va  [N];
        logic [31:0] vb  [N];
        logic [31:0] elo [N];
        logic [31:0] ehi [N];
        int          fin;
        ops = '{EXE_DIVU_OP, EXE_DIVU_OP, EXE_DIV_OP, EXE_DIV_OP,
                EXE_DIV_OP, EXE_DIVU_OP, EXE_DIVU_OP, EXE_DIV_OP};
        va  = '{32'd100, 32'hFFFF_FFFF, 32'h0000_1234,
                32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9,
                32'd5, 32'hFFFF_FFF9};
        vb  = '{32'd7, 32'h10, 32'd0, 32'd2, 32'hFFFF_FFFF,
                32'd2, 32'd0, 32'd0};
`ifdef EX_DIV_SIGNED_EN
        elo = '{32'd14, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
                32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFC,
                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ehi = '{32'd2, 32'hF, 32'h0000_1234, 32'hFFFF_FFFF,
                32'd0, 32'd1, 32'd5, 32'hFFFF_FFF9};
`else
        elo = '{32'd14, 32'h0FFF_FFFF, 32'hFFFF_FFFF,
                32'h7FFF_FFFC, 32'd0, 32'h7FFF_FFFC,
                32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ehi = '{32'd2, 32'hF, 32'h0000_1234, 32'd1,
                32'h8000_0000, 32'd1, 32'd5, 32'hFFFF_FFF9};
`endif
        for (int i = 0; i < N; i++) begin
            fin = (vb[i] == 32'd0) ? 2 : 33;
            drive(ops[i], EXE_RES_NOP, va[i], vb[i], 1'b1, 5'd7);
            for (int k = 0; k <= fin; k++) begin
                @(negedge clk);
                compared++;
                if (bus.stallreq_o !== (k < fin)) begin
                    mismatched++;
                    $display("FAIL div[%0d]_stall@%0d: got %b expected %b",
                             i, k, bus.stallreq_o, k < fin);
                end
                compared++;
                if (bus.mem_whilo_o !== (k == fin)) begin
                    mismatched++;
                    $display("FAIL div[%0d]_whilo@%0d: got %b expected %b",
                             i, k, bus.mem_whilo_o, k == fin);
                end
                if (k == fin) begin
                    compared++;
                    if (bus.mem_lo_o !== elo[i] ||
                        bus.mem_hi_o !== ehi[i]) begin
                        mismatched++;
                        $display("FAIL div[%0d]_result: got lo %h hi %h expected lo %h hi %h",
                                 i, bus.mem_lo_o, bus.mem_hi_o,
                                 elo[i], ehi[i]);
                    end
                    compared++;
                    if (bus.mem_we_o !== 1'b0) begin
                        mismatched++;
                        $display("FAIL div[%0d]_we: got %b expected 0",
                                 i, bus.mem_we_o);
                    end
                end else if (k == 1) begin
                    compared++;
                    if ({bus.mem_hi_o, bus.mem_lo_o} !== 64'd0) begin
                        mismatched++;
                        $display("FAIL div[%0d]_hilo_busy: got %h %h expected 0 0",
                                 i, bus.mem_hi_o, bus.mem_lo_o);
                    end
                end
                next_cycle();
            end
        end
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        compared++;
        if (bus.stallreq_o !== 1'b0) begin
            mismatched++;
            $display("FAIL div_after_idle: got %b expected 0",
                     bus.stallreq_o);
        end
        next_cycle();
    endtask

    task automatic test_abort;
        logic seen;
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b1, 5'd4);
        repeat (10) next_cycle();
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b1, 5'd4);
        @(negedge clk);
        compared++;
        if (bus.stallreq_o !== 1'b1) begin
            mismatched++;
            $display("FAIL abort_stall_busy: got %b expected 1",
                     bus.stallreq_o);
        end
        next_cycle();
        @(negedge clk);
        compared++;
        if (bus.stallreq_o !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_stall_after: got %b expected 0",
                     bus.stallreq_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | (bus.mem_whilo_o !== 1'b0);
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_whilo: got pulse %b expected 0", seen);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        logic seen;
        drive(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 1'b1, 5'd4);
        repeat (10) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (bus.stallreq_o !== 1'b0 || bus.mem_whilo_o !== 1'b0 ||
            {bus.mem_hi_o, bus.mem_lo_o} !== 64'd0) begin
            mismatched++;
            $display("FAIL rst_mid_outputs: got stall %b whilo %b hi %h lo %h expected 0",
                     bus.stallreq_o, bus.mem_whilo_o,
                     bus.mem_hi_o, bus.mem_lo_o);
        end
        next_cycle();
        rst = 1'b1;
        drive(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 1'b0, 5'd0);
        @(negedge clk);
        compared++;
        if (bus.stallreq_o !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_stall_after: got %b expected 0",
                     bus.stallreq_o);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | (bus.mem_whilo_o !== 1'b0);
        end
        compared++;
        if (seen !== 1'b0) begin
            mismatched++;
            $display("FAIL rst_mid_whilo: got pulse %b expected 0",
                     seen);
        end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_logic();
        test_shift();
        test_arith();
        test_abort();
        test_reset_mid();
        test_div_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage pipeline. It consumes the operands and control fields registered by the ID/EX pipeline register and computes the ALU result for the EX/MEM register. It also owns a multi-cycle iterative divider that writes HI/LO. While a divide runs, the block holds the pipeline through a stall request.

## Interface
Parameters:
- DATA_W, 32, operand/result width (`RegBus`)
- DIV_ITER, 32, divider iterations (equals DATA_W)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ex_data_a_i  in  32  operand A from ID/EX
- ex_data_b_i  in  32  operand B from ID/EX
- ex_we_i  in  1  register-file write enable from ID/EX
- ex_w_reg_addr_i  in  5  destination register from ID/EX
- ex_sel_i  in  3  result class (`AluSelBus`)
- ex_op_i  in  8  operation (`AluOpBus`)
- mem_we_o  out  1  write enable to EX/MEM
- mem_w_reg_addr_o  out  5  destination register to EX/MEM
- mem_wdata_o  out  32  result to EX/MEM
- mem_whilo_o  out  1  HI/LO write enable
- mem_hi_o, mem_lo_o  out  32 each  HI (remainder) and LO (quotient)
- stallreq_o  out  1  hold PC, IF/ID and ID/EX this cycle

## Operation
- Result classes (ex_sel_i):
  - LOGIC: AND, OR, XOR, NOR.
  - SHIFT: SLL, SRL, SRA; the amount is ex_data_a_i[4:0] and the shifted value is ex_data_b_i.
  - ARITH: ADD and SUB wrap modulo 2^32 with no overflow trap. SLT is a signed compare and SLTU an unsigned compare; both produce 32'd1 or 32'd0.
  - NOP: mem_wdata_o = 0.
- Pass-through: mem_we_o and mem_w_reg_addr_o follow ex_we_i and ex_w_reg_addr_i combinationally.
- Divide ops (DIV, DIVU): mem_we_o is forced to 0 and the result is written to HI/LO only.
- Divider FSM states: IDLE, BUSY, BYZERO, END.
  - IDLE → BYZERO when a divide op is present and B == 0.
  - IDLE → BUSY when a divide op is present and B != 0. On entry, the operands, a 6-bit counter (cleared) and a 65-bit shift register are latched.
  - BUSY: one restoring shift-subtract step per cycle. After DIV_ITER steps, go to END.
  - BYZERO → END after one cycle. The result is LO = 32'hFFFF_FFFF, HI = dividend.
  - END: mem_whilo_o = 1 and the quotient/remainder drive mem_lo_o/mem_hi_o. Go to IDLE next cycle unconditionally.
- Abort: if ex_op_i is no longer a divide while in BUSY or BYZERO (pipeline flush), return to IDLE next cycle with no HI/LO write.
- stallreq_o = 1 when (IDLE and divide op present) or BUSY or BYZERO; otherwise 0.
- Outside END, mem_whilo_o = 0 and mem_hi_o = mem_lo_o = 0.

## Timing
- Non-divide ops: combinational, zero cycles added; the result is captured by EX/MEM at the next edge.
- Divide accepted in cycle T (nonzero divisor):
  - stallreq_o high T..T+32
  - BUSY T+1..T+32
  - END and whilo at T+33
  - IDLE at T+34
- Divide by zero: stallreq_o high T..T+1, END at T+2.
- Reset: async assertion forces IDLE and clears the counter and datapath registers. In any cycle with rst low, all registered state reads zero and stallreq_o, mem_whilo_o, mem_hi_o and mem_lo_o are 0. A reset mid-divide discards the divide.
- ID/EX must hold its outputs while stallreq_o is high. This block relies on stable inputs through END.

## Configuration
- EX_DIV_SIGNED_EN defined: DIV is signed.
  - The divider runs on magnitudes.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - 32'h8000_0000 / 32'hFFFF_FFFF gives LO = 32'h8000_0000, HI = 0.
- EX_DIV_SIGNED_EN undefined: DIV decodes identically to DIVU (unsigned), and the sign-fixup logic is absent.

## Structure
- Shared defines file holds: op codes (EXE_*_OP), result classes (EXE_RES_*), bus widths, and the divider state encodings (DIV_IDLE, DIV_BUSY, DIV_BYZERO, DIV_END).
- One sub-module, ex_div, contains the FSM, counter and shift-subtract datapath.
  - Inputs: start, signed, op_a, op_b, cancel.
  - Outputs: busy, done, quotient, remainder.
- ex_stage keeps the ALU muxing and the stall logic.

## Test plan
- ADD 32'h7FFF_FFFF + 1 → mem_wdata_o = 32'h8000_0000, stallreq_o = 0, mem_we_o follows ex_we_i.
- SRA with A = 4, B = 32'hF000_0000 → 32'hFF00_0000. SLT -1 < 1 → 1; SLTU on the same operands → 0.
- DIVU 100/7 at cycle T → stallreq_o high T..T+32; at T+33 LO = 14, HI = 2, whilo = 1, mem_we_o = 0.
- DIV by 0 → stall for 2 cycles; END at T+2 with LO = 32'hFFFF_FFFF, HI = dividend.
- With EX_DIV_SIGNED_EN: DIV -7/2 → LO = 32'hFFFF_FFFD, HI = 32'hFFFF_FFFF. Without it: unsigned result.
- Reset low at BUSY cycle 10, or ex_op_i changed to NOP at BUSY cycle 10 → state IDLE, no whilo pulse, stallreq_o = 0 on the following cycle.
